// File: rtl/if_stage_ibuf_pkg.sv
// if_stage_ibuf_pkg: shared fetch-stage constants and helpers.
package if_stage_ibuf_pkg;
    localparam int CPU_XLEN = 32;
    localparam logic [1:0] SRAM_SIZE_WORD = 2'b10;
    function automatic logic misaligned(input logic [1:0] lo);
        return lo != 2'b00;
    endfunction
endpackage

// File: rtl/if_stage_ibuf_if.sv
// if_stage_ibuf_if: instruction SRAM req/addr_ok/data_ok bus.
interface if_stage_ibuf_if import if_stage_ibuf_pkg::*; #(parameter int XLEN = CPU_XLEN);
    logic req;
    logic wr;
    logic [1:0] size;
    logic [3:0] wstrb;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic addr_ok;
    logic data_ok;
    logic [XLEN-1:0] rdata;
    modport master(output req, wr, size, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
    modport slave(input req, wr, size, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/gnrl_dfflr.sv
// gnrl_dfflr: load-enabled flop with asynchronous active-high reset to zero.
module gnrl_dfflr #(parameter int DW = 1) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);
    always_ff @(posedge clk or posedge rst)
        if (rst) qout <= '0;
        else if (lden) qout <= dnxt;
endmodule

// File: rtl/if_ibuf.sv
// if_ibuf: synchronous FIFO with flush; push while full is accepted only alongside a pop.
module if_ibuf #(parameter int DW = 65, parameter int DEPTH = 2) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [DEPTH-1:0][DW-1:0] mem;
    logic [AW-1:0] wptr, rptr;
    logic wen, ren;
    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    assign wen = push && (!full || pop) && !flush;
    assign ren = pop && !empty && !flush;
    assign dout = mem[rptr];
    for (genvar i = 0; i < DEPTH; i++) begin : g_mem
        gnrl_dfflr #(.DW(DW)) u_ent (.clk(clk), .rst(rst), .lden(wen && wptr == AW'(i)), .dnxt(din), .qout(mem[i]));
    end
    gnrl_dfflr #(.DW(AW)) u_wptr (.clk(clk), .rst(rst), .lden(1'b1),
        .dnxt(flush ? '0 : wptr + AW'(wen)), .qout(wptr));
    gnrl_dfflr #(.DW(AW)) u_rptr (.clk(clk), .rst(rst), .lden(1'b1),
        .dnxt(flush ? '0 : rptr + AW'(ren)), .qout(rptr));
    gnrl_dfflr #(.DW(CW)) u_cnt (.clk(clk), .rst(rst), .lden(1'b1),
        .dnxt(flush ? '0 : count + CW'(wen) - CW'(ren)), .qout(count));
endmodule

// File: rtl/if_stage_ibuf.sv
// if_stage_ibuf: fetch stage with one outstanding SRAM request, branch cancel,
// ADEF flagging and a registered instruction buffer towards decode.
module if_stage_ibuf import if_stage_ibuf_pkg::*; #(
    parameter int              XLEN       = CPU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(32'hbfc00000),
    parameter int              IBUF_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ds_allowin,
    input  logic [XLEN:0]        br_bus,
    if_stage_ibuf_if.master      inst_sram,
    output logic                 fs_to_ds_valid,
    output logic [2*XLEN:0]      fs_to_ds_bus
);
    localparam int CW = $clog2(IBUF_DEPTH) + 1;
    logic br_taken;
    logic [XLEN-1:0] br_target, fetch_pc, req_pc;
    logic outstanding, cancel, adef_stall;
    logic accept, ret, push_inst, push_adef, pop, empty, full;
    logic [CW-1:0] count;
    assign {br_taken, br_target} = br_bus;
    assign inst_sram.wr = 1'b0;
    assign inst_sram.size = SRAM_SIZE_WORD;
    assign inst_sram.wstrb = '0;
    assign inst_sram.wdata = '0;
    assign inst_sram.addr = fetch_pc;
    // The outstanding request already owns a buffer slot, so it counts against capacity.
    assign inst_sram.req = !reset && !adef_stall && !misaligned(fetch_pc[1:0])
                        && (!outstanding || inst_sram.data_ok)
                        && (count + CW'(outstanding) < CW'(IBUF_DEPTH));
    assign accept = inst_sram.req && inst_sram.addr_ok;
    assign ret = inst_sram.data_ok && outstanding;
    assign push_inst = ret && !cancel && !br_taken;
    assign push_adef = misaligned(fetch_pc[1:0]) && !adef_stall && !outstanding && !full && !br_taken;
    assign pop = fs_to_ds_valid && ds_allowin;
    assign fs_to_ds_valid = !empty;
    if_ibuf #(.DW(2*XLEN+1), .DEPTH(IBUF_DEPTH)) u_ibuf (
        .clk(clk),
        .rst(reset),
        .push(push_inst || push_adef),
        .pop(pop),
        .flush(br_taken),
        .din(push_adef ? {1'b1, fetch_pc, XLEN'(0)} : {1'b0, req_pc, inst_sram.rdata}),
        .dout(fs_to_ds_bus),
        .count(count),
        .empty(empty),
        .full(full)
    );
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            fetch_pc <= RESET_PC;
            req_pc <= '0;
            outstanding <= 1'b0;
            cancel <= 1'b0;
            adef_stall <= 1'b0;
        end else begin
            fetch_pc <= br_taken ? br_target : accept ? fetch_pc + XLEN'(4) : fetch_pc;
            req_pc <= accept ? fetch_pc : req_pc;
            outstanding <= accept || (outstanding && !inst_sram.data_ok);
            cancel <= br_taken ? ((outstanding && !inst_sram.data_ok) || accept) : cancel && !ret;
            adef_stall <= !br_taken && (adef_stall || push_adef);
        end
endmodule

// File: tb/tb_if_stage_ibuf.sv
// tb_if_stage_ibuf: table vectors, directed redirect/ADEF/reset sequences and a
// randomized run checked against an in-order fetch-stream model.
module tb_if_stage_ibuf;
    import if_stage_ibuf_pkg::*;
    localparam logic [31:0] RPC = 32'hbfc00000;
    logic clk = 1'b0, reset = 1'b1, ds_allowin = 1'b0;
    logic [32:0] br_bus = '0;
    logic fs_to_ds_valid;
    logic [64:0] fs_to_ds_bus;
    if_stage_ibuf_if #(.XLEN(32)) mem ();
    if_stage_ibuf #(.XLEN(32), .RESET_PC(RPC), .IBUF_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .ds_allowin(ds_allowin), .br_bus(br_bus),
        .inst_sram(mem), .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus)
    );
    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, pops = 0;
    bit pend, hold, adef_done;
    logic [31:0] pend_addr, exp_issue, exp_pc, hold_addr;
    logic s_req, s_valid;
    logic [31:0] s_addr;
    logic [64:0] s_bus;

    typedef struct {bit ao; bit dok; bit al; bit req; logic [31:0] addr; bit valid; logic [31:0] pc;} vec_t;
    vec_t tbl[17];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h3c5a0f69;
    endfunction

    task automatic model_reset();
        pend = 0; hold = 0; adef_done = 0;
        exp_issue = RPC; exp_pc = RPC;
    endtask

    // One bus cycle: memory answers the single pending request when dok allows.
    // The model only knows the fetch stream is consecutive from the last redirect.
    task automatic cyc(input bit ao, input bit dok, input bit al, input bit br, input logic [31:0] tgt);
        bit dv;
        dv = pend && dok;
        mem.data_ok = dv;
        mem.rdata = dv ? inst_of(pend_addr) : $urandom;
        mem.addr_ok = ao;
        ds_allowin = al;
        br_bus = {br, tgt};
        @(negedge clk);
        s_req = mem.req; s_addr = mem.addr; s_valid = fs_to_ds_valid; s_bus = fs_to_ds_bus;
        if (hold) begin
            chk("hold_req", s_req, 1);
            chk("hold_addr", s_addr, hold_addr);
        end
        if (exp_issue[1:0] != 2'b00) chk("adef_noreq", s_req, 0);
        if (s_req && ao) begin
            chk("issue_addr", s_addr, exp_issue);
            chk("one_outstanding", pend && !dv, 0);
        end
        if (adef_done && !br) chk("adef_quiet", s_valid, 0);
        else if (s_valid && al && !br) begin
            if (exp_pc[1:0] != 2'b00) begin
                chk("pop_adef", s_bus, {1'b1, exp_pc, 32'h0});
                adef_done = 1;
            end else begin
                chk("pop_inst", s_bus, {1'b0, exp_pc, inst_of(exp_pc)});
                exp_pc += 4;
            end
            pops++;
        end
        hold = s_req && !ao && !br;
        hold_addr = s_addr;
        @(posedge clk); #1;
        if (s_req && ao) begin pend = 1; pend_addr = s_addr; end
        else if (dv) pend = 0;
        if (br) begin exp_issue = tgt; exp_pc = tgt; adef_done = 0; end
        else if (s_req && ao) exp_issue += 4;
    endtask

    initial begin
        logic [31:0] tgt;
        int base;
        tbl[0]  = '{1, 0, 1, 1, RPC + 32'h00, 0, 0};
        tbl[1]  = '{1, 1, 1, 1, RPC + 32'h04, 0, 0};
        tbl[2]  = '{1, 1, 1, 0, 0, 1, RPC + 32'h00};
        tbl[3]  = '{1, 0, 1, 1, RPC + 32'h08, 1, RPC + 32'h04};
        tbl[4]  = '{1, 1, 1, 1, RPC + 32'h0c, 0, 0};
        tbl[5]  = '{1, 1, 1, 0, 0, 1, RPC + 32'h08};
        tbl[6]  = '{1, 0, 0, 1, RPC + 32'h10, 1, RPC + 32'h0c};
        tbl[7]  = '{1, 1, 0, 0, 0, 1, RPC + 32'h0c};
        tbl[8]  = '{1, 0, 0, 0, 0, 1, RPC + 32'h0c};
        tbl[9]  = '{1, 0, 0, 0, 0, 1, RPC + 32'h0c};
        tbl[10] = '{1, 0, 1, 0, 0, 1, RPC + 32'h0c};
        tbl[11] = '{1, 0, 0, 1, RPC + 32'h14, 1, RPC + 32'h10};
        tbl[12] = '{1, 1, 0, 0, 0, 1, RPC + 32'h10};
        tbl[13] = '{1, 0, 1, 0, 0, 1, RPC + 32'h10};
        tbl[14] = '{1, 0, 1, 1, RPC + 32'h18, 1, RPC + 32'h14};
        tbl[15] = '{1, 0, 1, 0, 0, 0, 0};
        tbl[16] = '{1, 1, 1, 1, RPC + 32'h1c, 0, 0};
        mem.addr_ok = 0; mem.data_ok = 0; mem.rdata = '0;
        #2;
        chk("rst_req", mem.req, 0);
        chk("rst_valid", fs_to_ds_valid, 0);
        chk("rst_bus", fs_to_ds_bus, 0);
        chk("const_wr", mem.wr, 0);
        chk("const_size", mem.size, SRAM_SIZE_WORD);
        chk("const_wstrb", mem.wstrb, 0);
        chk("const_wdata", mem.wdata, 0);
        @(posedge clk); #1;
        reset = 0;
        model_reset();
        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].ao, tbl[i].dok, tbl[i].al, 0, 0);
            chk($sformatf("t%0d_req", i), s_req, tbl[i].req);
            if (tbl[i].req) chk($sformatf("t%0d_addr", i), s_addr, tbl[i].addr);
            chk($sformatf("t%0d_valid", i), s_valid, tbl[i].valid);
            if (tbl[i].valid) begin
                chk($sformatf("t%0d_pc", i), s_bus[63:32], tbl[i].pc);
                chk($sformatf("t%0d_inst", i), s_bus[31:0], inst_of(tbl[i].pc));
                chk($sformatf("t%0d_adef", i), s_bus[64], 0);
            end
        end
        // Async reset with a request outstanding and the buffer holding its other slot.
        mem.addr_ok = 0; mem.data_ok = 0; ds_allowin = 0; br_bus = '0;
        #2;
        chk("prerst_valid", fs_to_ds_valid, 1);
        reset = 1;
        #1;
        chk("arst_req", mem.req, 0);
        chk("arst_valid", fs_to_ds_valid, 0);
        chk("arst_bus", fs_to_ds_bus, 0);
        model_reset();
        @(posedge clk); #1;
        reset = 0;
        mem.data_ok = 1; mem.rdata = $urandom; mem.addr_ok = 0; ds_allowin = 1;
        @(negedge clk);
        chk("stale_req", mem.req, 1);
        chk("stale_addr", mem.addr, RPC);
        chk("stale_valid", fs_to_ds_valid, 0);
        @(posedge clk); #1;
        cyc(1, 0, 1, 0, 0);
        chk("stale_dropped", s_valid, 0);
        // Branch while a fetch is in flight: returning data must be dropped.
        cyc(0, 1, 1, 1, 32'hbfc00010);
        cyc(1, 0, 1, 0, 0);
        chk("c3_req", s_req, 1);
        chk("c3_addr", s_addr, 32'hbfc00010);
        cyc(0, 0, 1, 1, 32'hbfc00100);
        cyc(0, 1, 1, 0, 0);
        chk("c3_redir_addr", s_addr, 32'hbfc00100);
        cyc(1, 0, 1, 0, 0);
        chk("c3_dropped", s_valid, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("c3_new_valid", s_valid, 1);
        chk("c3_new_pc", s_bus[63:32], 32'hbfc00100);
        // Branch coinciding with data_ok and a decode pop.
        cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 1, 1, 1, 32'hbfc00300);
        cyc(0, 0, 1, 0, 0);
        chk("c4_valid", s_valid, 0);
        chk("c4_req", s_req, 1);
        chk("c4_addr", s_addr, 32'hbfc00300);
        // Misaligned redirect yields one ADEF entry, then fetch halts.
        cyc(0, 0, 1, 1, 32'hbfc00102);
        cyc(1, 0, 0, 0, 0);
        chk("c5_noreq", s_req, 0);
        cyc(1, 0, 1, 0, 0);
        chk("c5_valid", s_valid, 1);
        chk("c5_bus", s_bus, {1'b1, 32'hbfc00102, 32'h0});
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 1, 0, 0);
            chk("c5_halt_valid", s_valid, 0);
            chk("c5_halt_req", s_req, 0);
        end
        cyc(0, 0, 1, 1, 32'hbfc00200);
        cyc(1, 0, 1, 0, 0);
        chk("c5_resume_req", s_req, 1);
        chk("c5_resume_addr", s_addr, 32'hbfc00200);
        base = pops;
        for (int i = 0; i < 3000; i++) begin
            bit br;
            br = $urandom_range(0, 19) == 0;
            tgt = RPC + 32'($urandom_range(0, 255)) * 4 + (($urandom_range(0, 3) == 0) ? 32'd2 : 32'd0);
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7, br, tgt);
        end
        chk("liveness", (pops - base) > 200, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
